tree_router_split: RTL

TREE_ROUTER_SPLIT -- requirements
Module: tree_router_split

---
 rtl/noc_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/tree_router_split.sv | 128 ++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: router FSM state type and the route-decision rule.
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_DATA = 2'd2
  } route_state_t;

  // Returns the output port (0 or 1) for a destination field.
  // Leaf nodes match a masked address; interior nodes branch on the address
  // bit belonging to their tree level (MSB first).
  function automatic logic route_port(
    input logic [31:0] dest,
    input int          addr_w,
    input logic        leaf,
    input logic [31:0] node_addr,
    input logic [31:0] node_mask,
    input int          level
  );
    logic p;
    if (leaf) p = ((dest & node_mask) != node_addr);
    else      p = dest[addr_w - 1 - level];
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. Push is ignored when full, pop when empty;
// the head entry is visible on pop_data whenever empty is low.
module sync_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tree_router_split.sv
// Binary tree router node: buffers input packets, announces the chosen port
// on the select side channel, then presents the packet on that port.
// Handshake rule on every channel: a transfer happens when valid and ready are
// both high at a rising edge; once valid is raised it stays high with its data
// unchanged until that transfer. No ready input reaches any output combinationally.
module tree_router_split
  import noc_pkg::*;
#(
  parameter int                DATA_W    = 9,
  parameter int                ADDR_W    = 4,
  parameter int                ADDR_LSB  = 5,
  parameter int                LEAF      = 0,
  parameter logic [ADDR_W-1:0] NODE_ADDR = 4'b0110,
  parameter logic [ADDR_W-1:0] NODE_MASK = 4'b1110,
  parameter int                LEVEL     = 3,
  parameter int                DEPTH     = 2,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              s_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output route_state_t      dbg_state
);

  route_state_t      state;
  logic              ready_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_dout;
  logic [ADDR_W-1:0] dest;
  logic              route;
  logic [DATA_W-1:0] data_q;
  logic              port_q;
  logic              hs0;
  logic              hs1;

  // ready_en keeps in_ready low for the first cycle out of reset.
  assign in_ready  = ready_en && !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign dest      = fifo_dout[ADDR_LSB +: ADDR_W];
  assign route     = route_port(32'(dest), ADDR_W, (LEAF != 0), 32'(NODE_ADDR),
                                32'(NODE_MASK), LEVEL);
  assign s_data    = port_q;
  assign out0_data = data_q;
  assign out1_data = data_q;
  assign hs0       = out0_valid && out0_ready;
  assign hs1       = out1_valid && out1_ready;
  assign dbg_state = state;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Route FSM: take the FIFO head, announce its port, then deliver it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ready_en   <= 1'b0;
      data_q     <= '0;
      port_q     <= 1'b0;
      s_valid    <= 1'b0;
      out0_valid <= 1'b0;
      out1_valid <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            data_q  <= fifo_dout;
            port_q  <= route;
            s_valid <= 1'b1;
            state   <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (s_ready) begin
            s_valid    <= 1'b0;
            out0_valid <= !port_q;
            out1_valid <= port_q;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (port_q ? out1_ready : out0_ready) begin
            out0_valid <= 1'b0;
            out1_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-port delivered-packet counters; saturate at all-ones, clear has priority.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (hs0 && (cnt0 != '1)) cnt0 <= cnt0 + 1'b1;
      if (hs1 && (cnt1 != '1)) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule
